// File: rtl/cla_pkg.sv
// Shared constants and helpers for the CLA accumulator datapath.
package cla_pkg;

    // FSM state encoding (2 bits; 2'b11 is unreachable and recovers to IDLE)
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ACCUM = 2'b01;
    localparam logic [1:0] S_HOLD  = 2'b10;

    // Carry-lookahead group size used by the adder
    localparam int CLA_BLK = 4;

    // Ceiling log2, usable in parameter expressions; cla_clog2(1) == 0
    function automatic int cla_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_adder_n.sv
// N-bit carry-lookahead adder built from 4-bit groups. Each group exposes a
// group generate/propagate pair; carries inside a group are flattened
// sum-of-products expressions of the group carry-in.
module cla_adder_n
    import cla_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NB = (N + CLA_BLK - 1) / CLA_BLK;

    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic [N-1:0]  c;
    logic [NB-1:0] blk_g;
    logic [NB-1:0] blk_p;
    logic [NB:0]   blk_c;
    logic          cc;
    logic          pp;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate/propagate for each CLA block
    always_comb begin
        blk_g = '0;
        blk_p = '1;
        for (int bi = 0; bi < NB; bi++) begin
            for (int i = 0; i < CLA_BLK; i++) begin
                if (bi * CLA_BLK + i < N) begin
                    blk_g[bi] = g[bi*CLA_BLK+i] | (p[bi*CLA_BLK+i] & blk_g[bi]);
                    blk_p[bi] = blk_p[bi] & p[bi*CLA_BLK+i];
                end
            end
        end
    end

    // Group carries from group G/P, then per-bit lookahead carries inside each group
    always_comb begin
        blk_c    = '0;
        c        = '0;
        cc       = 1'b0;
        pp       = 1'b0;
        blk_c[0] = cin;
        for (int bi = 0; bi < NB; bi++) begin
            blk_c[bi+1]    = blk_g[bi] | (blk_p[bi] & blk_c[bi]);
            c[bi*CLA_BLK]  = blk_c[bi];
            for (int i = 0; i < CLA_BLK - 1; i++) begin
                if (bi * CLA_BLK + i + 1 < N) begin
                    cc = blk_c[bi];
                    for (int j = 0; j <= i; j++) begin
                        cc = cc & p[bi*CLA_BLK+j];
                    end
                    for (int j = 0; j <= i; j++) begin
                        pp = g[bi*CLA_BLK+j];
                        for (int k = j + 1; k <= i; k++) begin
                            pp = pp & p[bi*CLA_BLK+k];
                        end
                        cc = cc | pp;
                    end
                    c[bi*CLA_BLK+i+1] = cc;
                end
            end
        end
    end

    assign sum  = p ^ c;
    assign cout = blk_c[NB];

endmodule

// File: rtl/cla_accumulator.sv
// Sums N_OPS unsigned operands from a valid/ready stream through a CLA and
// holds the batch result on a registered output handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | acc=0, count=0; first transfer loads acc with the operand
// S_ACCUM | batch in progress; each transfer adds through the CLA
// S_HOLD  | result presented (out_valid=1), in_ready=0 until drained
// 2'b11   | unreachable; recovers to S_IDLE with acc cleared
module cla_accumulator
    import cla_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int N_OPS = 4,
    localparam int CNT_W = cla_clog2(N_OPS) + 1,
    localparam int ACC_W = WIDTH + cla_clog2(N_OPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS);

    logic [1:0]       state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q,   out_sum_d;

    logic             in_xfer;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_cout;
    logic [CNT_W-1:0] count_inc;

    assign in_ready  = (state_q != S_HOLD);
    assign in_xfer   = in_valid && in_ready;
    assign in_ext    = ACC_W'(in_data);
    assign count_inc = count_q + 1'b1;

    cla_adder_n #(
        .N (ACC_W)
    ) u_adder (
        .a    (acc_q),
        .b    (in_ext),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state, accumulator, beat counter and output register logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        case (state_q)
            S_IDLE: begin
                acc_d   = '0;
                count_d = '0;
                if (in_xfer) begin
                    acc_d   = in_ext;
                    count_d = CNT_W'(1);
                    if (N_OPS == 1) begin
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                        out_sum_d   = in_ext;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (in_xfer) begin
                    acc_d   = add_sum;
                    count_d = count_inc;
                    if (count_inc == LAST_CNT) begin
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                        out_sum_d   = add_sum;
                    end
                end
            end
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d     = S_IDLE;
                    acc_d       = '0;
                    count_d     = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                acc_d       = '0;
                count_d     = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    // The accumulator is sized so an accepted add can never carry out
    always_ff @(posedge clk) begin
        if (!rst && in_xfer && state_q == S_ACCUM) begin
            assert (!add_cout);
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_cla_accumulator.sv
// Self-checking bench: two accumulators (N_OPS=4 and N_OPS=1) share one
// input stream and are compared every cycle against a batch-level model.
module tb_cla_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready4,  out_valid4;
    logic [5:0] out_sum4;
    logic       in_ready1,  out_valid1;
    logic [3:0] out_sum1;

    int n_checks = 0;
    int n_errors = 0;

    // per-instance model: index 0 -> N_OPS=4, index 1 -> N_OPS=1
    int m_cnt  [2];
    int m_acc  [2];
    int m_sum  [2];
    bit m_hold [2];

    always #5 clk = ~clk;

    cla_accumulator #(.WIDTH(4), .N_OPS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_data   (in_data),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_sum   (out_sum4)
    );

    cla_accumulator #(.WIDTH(4), .N_OPS(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_sum   (out_sum1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of batch semantics: collect n operands, present their sum,
    // hold it until taken; reset forgets everything.
    task automatic model_step(input int k, input int n);
        if (rst) begin
            m_cnt[k]  = 0;
            m_acc[k]  = 0;
            m_sum[k]  = 0;
            m_hold[k] = 0;
        end else if (m_hold[k]) begin
            if (out_ready) m_hold[k] = 0;
        end else if (in_valid) begin
            m_acc[k] = m_acc[k] + int'(in_data);
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == n) begin
                m_sum[k]  = m_acc[k];
                m_hold[k] = 1;
                m_acc[k]  = 0;
                m_cnt[k]  = 0;
            end
        end
    endtask

    // Advance one cycle with the currently driven inputs, then compare
    task automatic tick();
        @(posedge clk);
        model_step(0, 4);
        model_step(1, 1);
        #1;
        check("u4.in_ready",  32'(in_ready4),  32'(!m_hold[0]));
        check("u4.out_valid", 32'(out_valid4), 32'(m_hold[0]));
        check("u4.out_sum",   32'(out_sum4),   32'(m_sum[0]));
        check("u1.in_ready",  32'(in_ready1),  32'(!m_hold[1]));
        check("u1.out_valid", 32'(out_valid1), 32'(m_hold[1]));
        check("u1.out_sum",   32'(out_sum1),   32'(m_sum[1]));
    endtask

    task automatic beat(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        in_data  = 4'h0;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        logic [3:0] seq_a [4];
        foreach (m_cnt[k]) begin
            m_cnt[k] = 0; m_acc[k] = 0; m_sum[k] = 0; m_hold[k] = 0;
        end

        // reset with a live operand offered
        rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
        tick(); tick();
        check("rst.out_valid", 32'(out_valid4), 32'd0);
        check("rst.out_sum",   32'(out_sum4),   32'd0);
        check("rst.in_ready",  32'(in_ready4),  32'd1);
        rst = 1'b0;
        idle(2);
        check("rst.no_accum", 32'(out_valid4), 32'd0);

        // back-to-back 3,5,7,9
        seq_a = '{4'd3, 4'd5, 4'd7, 4'd9};
        foreach (seq_a[i]) beat(seq_a[i]);
        check("b2b.out_valid", 32'(out_valid4), 32'd1);
        check("b2b.out_sum",   32'(out_sum4),   32'd24);
        check("b2b.in_ready",  32'(in_ready4),  32'd0);
        idle(1);
        check("b2b.in_ready_after", 32'(in_ready4), 32'd1);

        // maximum operands
        for (int i = 0; i < 4; i++) beat(4'hF);
        check("max.out_sum", 32'(out_sum4), 32'h3C);
        idle(1);

        // backpressure while operands keep being offered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(4'hF);
        for (int i = 0; i < 5; i++) begin
            beat(4'h1);
            check("bp.held_sum", 32'(out_sum4),  32'h3C);
            check("bp.in_ready", 32'(in_ready4), 32'd0);
        end
        out_ready = 1'b1;
        beat(4'h1);
        check("bp.drained", 32'(out_valid4), 32'd0);
        for (int i = 0; i < 4; i++) beat(4'h1);
        check("bp.next_batch", 32'(out_sum4), 32'd4);
        idle(1);

        // gapped input
        seq_a = '{4'd1, 4'd2, 4'd4, 4'd8};
        foreach (seq_a[i]) begin
            beat(seq_a[i]);
            if (i < 3) begin
                idle(1);
                check("gap.in_ready", 32'(in_ready4),  32'd1);
                check("gap.no_out",   32'(out_valid4), 32'd0);
            end
        end
        check("gap.out_sum", 32'(out_sum4), 32'd15);
        idle(1);

        // reset mid-batch
        beat(4'd6); beat(4'd6);
        rst = 1'b1; idle(1); rst = 1'b0;
        for (int i = 0; i < 4; i++) beat(4'd1);
        check("midrst.out_sum", 32'(out_sum4), 32'd4);
        idle(1);

        // single-operand batches
        beat(4'd9);
        check("n1.out_valid", 32'(out_valid1), 32'd1);
        check("n1.out_sum",   32'(out_sum1),   32'd9);
        idle(1);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
